mbyte_alu_ctrl: RTL and testbench



---
 rtl/mbalu_pkg.sv | 49 ++++
 rtl/mbyte_alu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mbyte_alu_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbalu_pkg.sv
// Shared constants for the multi-byte ALU controller.
//   - cmd_op encodings accepted on the command channel
//   - opcodes understood by the 8-bit ALU
//   - controller FSM state encoding
//   - alu_opcode(): maps a command op to the per-byte ALU opcode
package mbalu_pkg;

    // Command channel operations
    localparam logic [2:0] CmdAdd  = 3'd0;
    localparam logic [2:0] CmdSub  = 3'd1;
    localparam logic [2:0] CmdAnd  = 3'd2;
    localparam logic [2:0] CmdOr   = 3'd3;
    localparam logic [2:0] CmdXor  = 3'd4;
    localparam logic [2:0] CmdNot  = 3'd5;

    // 8-bit ALU opcodes
    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluAdc   = 4'd1;
    localparam logic [3:0] AluSub   = 4'd2;
    localparam logic [3:0] AluSbc   = 4'd3;
    localparam logic [3:0] AluOr    = 4'd4;
    localparam logic [3:0] AluAnd   = 4'd5;
    localparam logic [3:0] AluNot   = 4'd6;
    localparam logic [3:0] AluXor   = 4'd7;
    localparam logic [3:0] AluPassA = 4'd8;
    localparam logic [3:0] AluPassB = 4'd9;
    localparam logic [3:0] AluNeg   = 4'd10;
    localparam logic [3:0] AluCmp   = 4'd11;

    // Controller FSM states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // SUB is issued as ADC with an inverted b and carry-in seeded to 1.
    function automatic logic [3:0] alu_opcode(input logic [2:0] op);
        logic [3:0] code;
        unique case (op)
            CmdAdd, CmdSub: code = AluAdc;
            CmdAnd:         code = AluAnd;
            CmdOr:          code = AluOr;
            CmdXor:         code = AluXor;
            CmdNot:         code = AluNot;
            default:        code = AluPassA;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mbyte_alu_ctrl.sv
// Multi-byte ALU controller. Takes a W-bit operation on the cmd channel, walks it through an
// external combinational 8-bit ALU one byte per cycle (LSB first, carry chained) and returns the
// assembled result with carry/zero flags on the rsp channel.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   cmd_valid/ready      command handshake; cmd_op, cmd_a, cmd_b carry the operation
//   rsp_valid/ready      response handshake; rsp_result, rsp_carry, rsp_zero
//   rsp_overflow         signed ADD/SUB overflow (only with MBALU_SIGNED_OVF_EN defined)
//   alu_a/b/carry/op     drive the external ALU (all zero outside RUN)
//   alu_c, alu_carry_out, alu_zero   ALU results, consumed in the same cycle
//
// Build option: define MBALU_SIGNED_OVF_EN to add the rsp_overflow output.
module mbyte_alu_ctrl
    import mbalu_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [8*NBYTES-1:0]   cmd_a,
    input  logic [8*NBYTES-1:0]   cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
`ifdef MBALU_SIGNED_OVF_EN
    output logic                  rsp_overflow,
`endif
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_carry,
    output logic [3:0]            alu_op,
    input  logic [7:0]            alu_c,
    input  logic                  alu_carry_out,
    input  logic                  alu_zero
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IdxW = $clog2(NBYTES);

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            cr_q, cr_d, za_q, za_d;

    logic       in_run, is_sub, is_arith, last_byte;
    logic [7:0] a_byte, b_byte;

    always_comb begin
        in_run    = (state_q == StRun);
        is_sub    = (op_q == CmdSub);
        is_arith  = (op_q == CmdAdd) || is_sub;
        last_byte = (idx_q == IdxW'(NBYTES - 1));
        a_byte    = a_q[8*idx_q +: 8];
        b_byte    = is_sub ? ~b_q[8*idx_q +: 8] : b_q[8*idx_q +: 8];
    end

    // ALU drive is gated to RUN so the shared ALU sees zeros while we are idle.
    always_comb begin
        alu_a     = in_run ? a_byte : 8'd0;
        alu_b     = (in_run && op_q != CmdNot) ? b_byte : 8'd0;
        alu_carry = in_run & cr_q;
        alu_op    = in_run ? alu_opcode(op_q) : 4'd0;
    end

    always_comb begin
        cmd_ready  = resetn && (state_q == StIdle);
        rsp_valid  = (state_q == StDone);
        rsp_result = res_q;
        rsp_carry  = cr_q;
        rsp_zero   = za_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cr_d    = cr_q;
        za_d    = za_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    res_d   = '0;
                    idx_d   = '0;
                    cr_d    = (cmd_op == CmdSub);
                    za_d    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[8*idx_q +: 8] = alu_c;
                za_d = za_q & alu_zero;
                cr_d = is_arith ? alu_carry_out : 1'b0;
                if (last_byte) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cr_q    <= 1'b0;
            za_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cr_q    <= cr_d;
            za_q    <= za_d;
        end
    end

`ifdef MBALU_SIGNED_OVF_EN
    // Sign of the effective b operand: SUB adds ~b.
    logic ovf_q, ovf_d, b_eff_msb;

    always_comb begin
        b_eff_msb = is_sub ? ~b_q[W-1] : b_q[W-1];
        ovf_d     = ovf_q;
        if (state_q == StIdle && cmd_valid) begin
            ovf_d = 1'b0;
        end else if (in_run && last_byte) begin
            // alu_c[7] is the MSB of the final result byte.
            ovf_d = is_arith && (a_q[W-1] == b_eff_msb) && (alu_c[7] != a_q[W-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rsp_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_mbyte_alu_ctrl.sv
// Bench for mbyte_alu_ctrl with NBYTES=4, including a behavioural 8-bit ALU next to the DUT.
// Expected responses are queued when a command is accepted and compared when the response
// handshake happens. Define MBALU_SIGNED_OVF_EN to also cover rsp_overflow.
module tb_mbyte_alu_ctrl;
    import mbalu_pkg::*;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic         clk, resetn;
    logic         cmd_valid, cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a, cmd_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_zero;
`ifdef MBALU_SIGNED_OVF_EN
    logic         rsp_overflow;
`endif
    logic [7:0]   alu_a, alu_b, alu_c;
    logic         alu_carry, alu_carry_out, alu_zero;
    logic [3:0]   alu_op;

    mbyte_alu_ctrl #(.NBYTES(NBYTES)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
`ifdef MBALU_SIGNED_OVF_EN
        .rsp_overflow  (rsp_overflow),
`endif
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry     (alu_carry),
        .alu_op        (alu_op),
        .alu_c         (alu_c),
        .alu_carry_out (alu_carry_out),
        .alu_zero      (alu_zero)
    );

    // Behavioural 8-bit ALU
    logic [8:0] alu_s;
    always_comb begin
        alu_s = '0;
        case (alu_op)
            AluAdd:   alu_s = {1'b0, alu_a} + {1'b0, alu_b};
            AluAdc:   alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry};
            AluOr:    alu_s = {1'b0, alu_a | alu_b};
            AluAnd:   alu_s = {1'b0, alu_a & alu_b};
            AluNot:   alu_s = {1'b0, ~alu_a};
            AluXor:   alu_s = {1'b0, alu_a ^ alu_b};
            AluPassA: alu_s = {1'b0, alu_a};
            default:  alu_s = '0;
        endcase
    end
    assign alu_c         = alu_s[7:0];
    assign alu_carry_out = alu_s[8];
    assign alu_zero      = (alu_s[7:0] == 8'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic car[0:15];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference model
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            CmdAdd: begin
                s       = {1'b0, a} + {1'b0, b};
                e.res   = s[W-1:0];
                e.carry = s[W];
                e.ovf   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            CmdSub: begin
                s       = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                e.res   = s[W-1:0];
                e.carry = s[W];
                e.ovf   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            CmdAnd:  e.res = a & b;
            CmdOr:   e.res = a | b;
            CmdXor:  e.res = a ^ b;
            CmdNot:  e.res = ~a;
            default: e.res = a;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Response scoreboard: compare on each response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_size", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_result", 64'(rsp_result), 64'(e.res));
                check_eq("rsp_carry", 64'(rsp_carry), 64'(e.carry));
                check_eq("rsp_zero", 64'(rsp_zero), 64'(e.zero));
`ifdef MBALU_SIGNED_OVF_EN
                check_eq("rsp_overflow", 64'(rsp_overflow), 64'(e.ovf));
`endif
            end
        end
    end

    // Offer a command and wait (bounded) for acceptance; returns cycles spent waiting.
    task automatic send_only(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output int waited);
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            check_eq("accept_timeout", 64'(cmd_ready), 64'd1);
        end else begin
            sb.push_back(model(op, a, b));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Count cycles from acceptance until rsp_valid, recording alu_carry per RUN cycle.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat < 16) car[lat] = alu_carry;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        int w;
        send_only(op, a, b, w);
        wait_valid(lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_result", 64'(rsp_result), 64'd0);
        check_eq("rst_alu_op", 64'(alu_op), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        do_op(CmdAdd, 32'h0000_00FF, 32'h0000_0001, lat);
        check_eq("latency", 64'(lat), 64'd5);

        do_op(CmdAdd, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        check_eq("alu_carry_b0", 64'(car[1]), 64'd0);
        for (int i = 2; i <= 4; i++) check_eq("alu_carry_bn", 64'(car[i]), 64'd1);

        do_op(CmdSub, 32'd5, 32'd7, lat);
        do_op(CmdSub, 32'd7, 32'd5, lat);
        do_op(CmdXor, 32'hA5A5_A5A5, 32'hA5A5_A5A5, lat);
        do_op(CmdNot, 32'h0F0F_0F0F, 32'h1234_5678, lat);
        do_op(CmdAnd, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
        do_op(CmdOr, 32'h8000_0001, 32'h0100_1000, lat);
        do_op(3'd6, 32'hDEAD_BEEF, 32'h1111_1111, lat);

        // Backpressure with a second command pending.
        rsp_ready = 1'b0;
        send_only(CmdAdd, 32'd1, 32'd2, w);
        wait_valid(lat);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = CmdAdd;
        cmd_a     = 32'd10;
        cmd_b     = 32'd20;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("bp_rsp_result", 64'(rsp_result), 64'd3);
            check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("hs_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        send_only(CmdAdd, 32'd10, 32'd20, w);
        check_eq("second_accept_wait", 64'(w), 64'd0);
        wait_valid(lat);
        @(posedge clk);
        #1;

        // Reset during the RUN cycle for byte 2.
        send_only(CmdAdd, 32'h4433_2211, 32'h0101_0101, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("run_b2_alu_a", 64'(alu_a), 64'h33);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_rsp_result", 64'(rsp_result), 64'd0);
        check_eq("mid_rst_rsp_carry", 64'(rsp_carry), 64'd0);
        check_eq("mid_rst_rsp_zero", 64'(rsp_zero), 64'd0);
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("mid_rst_alu_a", 64'(alu_a), 64'd0);
        check_eq("mid_rst_alu_op", 64'(alu_op), 64'd0);
`ifdef MBALU_SIGNED_OVF_EN
        check_eq("mid_rst_ovf", 64'(rsp_overflow), 64'd0);
`endif
        sb.delete();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        do_op(CmdAdd, 32'h1234_5678, 32'h0FED_CBA9, lat);
        check_eq("post_rst_latency", 64'(lat), 64'd5);

`ifdef MBALU_SIGNED_OVF_EN
        do_op(CmdAdd, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        do_op(CmdSub, 32'h8000_0000, 32'h0000_0001, lat);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
